// File: rtl/mul4_score_pkg.sv
// mul4_score_pkg: shared widths and FSM state type for the multiplier fitness scorer.
package mul4_score_pkg;
  localparam int WORD_W_DEF = 16;
  localparam int PROD_W = 64;
  localparam int SCORE_W = 32;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
endpackage

// File: rtl/popcount64.sv
// popcount64: combinational population count of a 64-bit word.
module popcount64 (
  input  logic [63:0] x_i,
  output logic [6:0]  cnt_o
);
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < 64; i++) cnt_o = cnt_o + 7'(x_i[i]);
  end
endmodule

// File: rtl/mul4_fitness_scorer.sv
// mul4_fitness_scorer: scores a candidate 4-word product against A*B per vector; MUL4_SCORER_EXACT_EN enables exact_cnt.
module mul4_fitness_scorer
  import mul4_score_pkg::*;
#(
  parameter int NUM_VECTORS = 64,
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WORD_W-1:0]   a1,
  input  logic [WORD_W-1:0]   a0,
  input  logic [WORD_W-1:0]   b1,
  input  logic [WORD_W-1:0]   b0,
  input  logic [WORD_W-1:0]   y3,
  input  logic [WORD_W-1:0]   y2,
  input  logic [WORD_W-1:0]   y1,
  input  logic [WORD_W-1:0]   y0,
  output logic                busy,
  output logic                done,
  output logic [SCORE_W-1:0]  score,
  output logic [15:0]         exact_cnt
);
  localparam int P = 4 * WORD_W;
  state_e state_q, state_d;
  logic [15:0] cnt_q;
  logic v1_q;
  logic [P-1:0] exp_q, y_q;
  logic [SCORE_W-1:0] score_q;
  logic [PROD_W-1:0] match;
  logic [6:0] pop;
  logic [SCORE_W:0] sum;
  logic accept, last, clear;
  assign accept = in_valid && state_q == RUN;
  assign last = accept && cnt_q == 16'(NUM_VECTORS - 1);
  assign clear = state_q == IDLE && start;
  assign in_ready = state_q == RUN;
  assign busy = state_q == RUN || state_q == DRAIN;
  assign done = state_q == DONE;
  assign score = score_q;
  assign match = PROD_W'(~(exp_q ^ y_q));
  assign sum = {1'b0, score_q} + (SCORE_W + 1)'(pop);
  popcount64 u_pop (.x_i(match), .cnt_o(pop));
  always_comb begin
    state_d = state_q;
    state_d = state_q == IDLE  ? (start ? RUN : IDLE) :
              state_q == RUN   ? (last ? DRAIN : RUN) :
              state_q == DRAIN ? (v1_q ? DRAIN : DONE) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      v1_q <= 1'b0;
      score_q <= '0;
    end else begin
      state_q <= state_d;
      v1_q <= accept;
      if (clear) begin
        cnt_q <= '0;
        score_q <= '0;
      end else begin
        if (accept) cnt_q <= cnt_q + 16'd1;
        if (v1_q) score_q <= sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
      end
    end
  end
  // Stage 1 datapath carries no reset; v1_q qualifies it.
  always_ff @(posedge clk) begin
    if (accept) begin
      exp_q <= P'({a1, a0}) * P'({b1, b0});
      y_q <= {y3, y2, y1, y0};
    end
  end
`ifdef MUL4_SCORER_EXACT_EN
  logic [15:0] exact_q;
  always_ff @(posedge clk) begin
    if (!rst_n) exact_q <= '0;
    else if (clear) exact_q <= '0;
    else if (v1_q && pop == 7'(P) && exact_q != '1) exact_q <= exact_q + 16'd1;
  end
  assign exact_cnt = exact_q;
`else
  assign exact_cnt = '0;
`endif
endmodule
